// File: rtl/cdc_tx_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_tx_burst_pkg
//  Description : Shared state encoding and width helpers for the CDC transmit
//                burst buffer and its byte FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_tx_burst_pkg;

    typedef logic [0:0] state_t;

    localparam state_t c_ST_IDLE  = 1'b0;
    localparam state_t c_ST_BURST = 1'b1;

    // Occupancy must be able to represent a completely full FIFO.
    function automatic int level_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    // Burst counter must be able to reach BURST_LEN itself.
    function automatic int burst_cnt_width(input int burst_len);
        return (burst_len < 2) ? 1 : $clog2(burst_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_byte_fifo
//  Description : Byte FIFO with registered occupancy, synchronous clear and a
//                combinational head (out_data = mem[rd_ptr]).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_byte_fifo
    import cdc_tx_burst_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_clear,
    input  logic                                i_push,
    input  logic [7:0]                          i_data,
    input  logic                                i_pop,
    output logic [7:0]                          o_head,
    output logic [level_width(DEPTH_LOG2)-1:0]  o_level
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;
    localparam int c_LW    = level_width(DEPTH_LOG2);

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [c_LW-1:0]       r_level;

    // Storage array; left unreset since occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/cdc_tx_burst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_tx_burst_buffer
//  Description : Collects user transmit bytes and hands them to the CDC IN
//                stream in bursts of up to BURST_LEN bytes. A burst starts on
//                a fill threshold, an idle timeout or a flush request; the
//                buffer is discarded while the USB link is down.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_tx_burst_buffer
    import cdc_tx_burst_pkg::*;
#(
    parameter int DEPTH_LOG2   = 6,
    parameter int BURST_LEN    = 32,
    parameter int IDLE_TIMEOUT = 60000,
    parameter int TIMER_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  usb_rstn,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy
);

    localparam int c_LW = level_width(DEPTH_LOG2);
    localparam int c_CW = burst_cnt_width(BURST_LEN);

    localparam logic [c_LW-1:0]    c_FULL_LVL  = c_LW'(2 ** DEPTH_LOG2);
    localparam logic [c_LW-1:0]    c_BURST_LVL = c_LW'(BURST_LEN);
    localparam logic [c_CW-1:0]    c_LAST_CNT  = c_CW'(BURST_LEN - 1);
    localparam logic [TIMER_W-1:0] c_TIMEOUT   = TIMER_W'(IDLE_TIMEOUT);

    state_t             r_state;
    logic [c_CW-1:0]    r_burst_cnt;
    logic               r_flush_pend;
    logic [TIMER_W-1:0] r_timer;

    logic [c_LW-1:0]    w_level;
    logic               w_clear;
    logic               w_push;
    logic               w_pop;
    logic               w_start;
    logic               w_burst_done;

    // Link-down acts as a synchronous clear of the whole buffer.
    assign w_clear   = !usb_rstn;

    // in_ready looks only at the registered level, so a pop never frees a
    // slot for a push in the same cycle.
    assign in_ready  = usb_rstn && (w_level != c_FULL_LVL);
    assign w_push    = in_valid && in_ready;

    // out_valid follows usb_rstn combinationally so it drops in the very
    // cycle the link goes away.
    assign out_valid = usb_rstn && (r_state == c_ST_BURST) && (w_level != '0);
    assign w_pop     = out_valid && out_ready;
    assign busy      = (r_state == c_ST_BURST);
    assign level     = w_level;

    assign w_start = (r_state == c_ST_IDLE) && (w_level != '0) &&
                     ((w_level >= c_BURST_LVL) || (r_timer == c_TIMEOUT) ||
                      r_flush_pend || flush);

    // A burst ends on its BURST_LEN-th pop, or when it runs dry with nothing
    // arriving to extend it.
    assign w_burst_done = (r_state == c_ST_BURST) &&
                          ((w_pop && (r_burst_cnt == c_LAST_CNT)) ||
                           ((w_level == '0) && !w_push));

    cdc_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (out_data),
        .o_level (w_level)
    );

    // Burst control: state, per-burst pop count and the sticky flush request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_burst_cnt  <= '0;
            r_flush_pend <= 1'b0;
        end else if (w_clear) begin
            r_state      <= c_ST_IDLE;
            r_burst_cnt  <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= c_ST_BURST;
                        r_burst_cnt  <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                default: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_pop) begin
                        r_burst_cnt <= r_burst_cnt + c_CW'(1);
                    end
                    if (w_burst_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Idle timer: counts quiet cycles while bytes wait in IDLE, saturating at
    // the timeout; zero whenever a burst is running or about to run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_clear || (r_state == c_ST_BURST) || w_start ||
                     w_push || (w_level == '0)) begin
            r_timer <= '0;
        end else if (r_timer != c_TIMEOUT) begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

endmodule
`default_nettype wire
